mod_fifo_param: RTL and testbench
=================================

Name: mod_fifo_param

Overview:
Parametrised synchronous FIFO. It generalises the single-entry byte FIFO to any data width and any power-of-two depth. It adds simultaneous read/write at full, almost-full/almost-empty thresholds, a synchronous flush, a read-valid strobe and sticky overflow/underflow flags. It buffers byte and word streams between the AES256 core stages (key expansion, state I/O) and the host interface.

Parameters:
DATA_W, 8, width of each data word in bits.
DEPTH, 16, number of entries; must be a power of two and at least 2.
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
Derived: ADDR_W = clog2(DEPTH); CNT_W = clog2(DEPTH)+1.

Ports:
clk  in  1  system clock; all logic acts on the rising edge.
rst  in  1  reset; synchronous, active-low.
clr  in  1  synchronous flush, active-high.
wr_en  in  1  write request.
buf_in  in  DATA_W  write data.
rd_en  in  1  read request.
buf_out  out  DATA_W  registered read data.
rd_valid  out  1  one-cycle strobe; buf_out carries newly popped data.
buf_empty  out  1  count == 0.
buf_full  out  1  count == DEPTH.
almost_empty  out  1  count <= AE_LEVEL.
almost_full  out  1  count >= AF_LEVEL.
fifo_counter  out  CNT_W  number of stored entries, 0..DEPTH.
overflow  out  1  sticky; set by a rejected write.
underflow  out  1  sticky; set by a rejected read.

Behaviour:
- Reset (rst==0 at posedge), highest priority:
  - wr_ptr=0, rd_ptr=0, fifo_counter=0, buf_out=0, rd_valid=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Resulting flags: buf_empty=1, buf_full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
- Flush (clr==1, rst==1), second priority:
  - Pointers, count, overflow and underflow go to 0; rd_valid=0.
  - buf_out holds its value.
  - wr_en/rd_en are ignored that cycle.
- Accept rules, evaluated on pre-edge state:
  - wr_acc = wr_en && (!buf_full || rd_en).
  - rd_acc = rd_en && !buf_empty.
- Write: when wr_acc, mem[wr_ptr] <= buf_in and wr_ptr increments, wrapping from DEPTH-1 to 0.
- Read: when rd_acc, buf_out <= mem[rd_ptr], rd_ptr increments with the same wrap, and rd_valid=1 next cycle. Otherwise rd_valid=0 and buf_out holds.
- Read latency: 1 cycle from the rd_en edge to data on buf_out. There is no first-word fall-through; a word written at edge N is readable by rd_en sampled at edge N+1 or later.
- Count:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both are accepted or neither is.
- Full plus simultaneous rd_en and wr_en: both are accepted. The popped word is the oldest entry, the new word fills the freed slot, count stays DEPTH, and overflow is not set.
- Empty plus simultaneous rd_en and wr_en: the write is accepted and the read is rejected. Count becomes 1, underflow=1, rd_valid=0.
- Error flags:
  - overflow <= 1 when wr_en && !wr_acc.
  - underflow <= 1 when rd_en && !rd_acc.
  - Both stay set until rst or clr.
- Status flags are combinational decodes of the fifo_counter register, so they are valid in the same cycle as the count. There are no combinational paths from inputs to outputs.
- Order is strict FIFO; no data loss occurs without overflow being flagged.

Test Plan (DATA_W=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1):
1. Reset then fill: rst=0 for 2 cycles, then write 0x11, 0x22, 0x33, 0x44.
   Counter goes 1, 2, 3, 4. almost_empty drops when the count reaches 2, almost_full rises at 3, buf_full rises at 4. A 5th write of 0x55 sets overflow=1 and the count stays 4.
2. Drain in order: from the full state, rd_en for 4 cycles.
   buf_out shows 0x11, 0x22, 0x33, 0x44, each one cycle after its rd_en, with rd_valid=1 each cycle. buf_empty=1 at the end. A further rd_en sets underflow=1, rd_valid=0, and buf_out holds 0x44.
3. Simultaneous at full: full with 0xA0..0xA3, then rd_en=wr_en=1 with buf_in=0xB0.
   buf_out=0xA0 and count stays 4 with no overflow. Draining returns 0xA1, 0xA2, 0xA3, 0xB0.
4. Simultaneous at empty: rd_en=wr_en=1 with buf_in=0x5A.
   Count=1, underflow=1, rd_valid=0. The next rd_en returns 0x5A.
5. Wrap-around: run 10 push/pop pairs with counts oscillating 0–3, incrementing data 0x00..0x09.
   Output order matches input exactly across pointer wrap.
6. Flush and reset mid-operation:
   - With 3 entries and overflow=1, pulse clr together with wr_en. Count=0, overflow=0, buf_out unchanged, and the write is dropped.
   - Separately, assert rst=0 during a read. buf_out=0 and rd_valid=0 next cycle.

Source files
------------

// File: rtl/mod_fifo_param.sv
// Parametrised synchronous FIFO with registered read port,
// threshold flags, flush and sticky error flags.
module mod_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] buf_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] buf_out,
  output logic              rd_valid,
  output logic              buf_empty,
  output logic              buf_full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [CNT_W-1:0]  fifo_counter,
  output logic              overflow,
  output logic              underflow
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  assign buf_empty    = (fifo_counter == '0);
  assign buf_full     = (fifo_counter == CNT_W'(DEPTH));
  assign almost_empty = (fifo_counter <= CNT_W'(AE_LEVEL));
  assign almost_full  = (fifo_counter >= CNT_W'(AF_LEVEL));

  // A read at full frees a slot, so the write may take it
  assign wr_acc = wr_en && (!buf_full || rd_en);
  assign rd_acc = rd_en && !buf_empty;

  always_ff @(posedge clk) begin
    if (rst && !clr && wr_acc) begin
      mem[wr_ptr] <= buf_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
      buf_out      <= '0;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (clr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        buf_out <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   fifo_counter <= fifo_counter + CNT_W'(1);
        2'b01:   fifo_counter <= fifo_counter - CNT_W'(1);
        default: fifo_counter <= fifo_counter;
      endcase
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_en && !rd_acc) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_fifo_param.sv
// Randomised and directed bench for mod_fifo_param
// against a queue-based reference model.
module tb_mod_fifo_param;

  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          wr_en;
  logic [DW-1:0] buf_in;
  logic          rd_en;
  logic [DW-1:0] buf_out;
  logic          rd_valid;
  logic          buf_empty;
  logic          buf_full;
  logic          almost_empty;
  logic          almost_full;
  logic [CW-1:0] fifo_counter;
  logic          overflow;
  logic          underflow;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_out;
  logic          m_valid;
  logic          m_ovf;
  logic          m_udf;

  always #5 clk = ~clk;

  mod_fifo_param #(
    .DATA_W(DW), .DEPTH(DEP), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .buf_in(buf_in), .rd_en(rd_en),
    .buf_out(buf_out), .rd_valid(rd_valid),
    .buf_empty(buf_empty), .buf_full(buf_full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .fifo_counter(fifo_counter),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d,
                      input logic r, input logic c = 1'b0,
                      input logic rs = 1'b1);
    bit wa, ra;
    rst = rs; clr = c; wr_en = w; buf_in = d; rd_en = r;
    @(posedge clk);
    if (!rs) begin
      q.delete(); m_out = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
    end else if (c) begin
      q.delete(); m_valid = 0; m_ovf = 0; m_udf = 0;
    end else begin
      wa = w && (q.size() < DEP || r);
      ra = r && q.size() > 0;
      m_valid = ra;
      if (ra) m_out = q.pop_front();
      if (wa) q.push_back(d);
      if (w && !wa) m_ovf = 1;
      if (r && !ra) m_udf = 1;
    end
    #1;
    chk("count", fifo_counter, q.size());
    chk("empty", buf_empty, q.size() == 0);
    chk("full", buf_full, q.size() == DEP);
    chk("aempty", almost_empty, q.size() <= 1);
    chk("afull", almost_full, q.size() >= 3);
    chk("rd_valid", rd_valid, m_valid);
    chk("buf_out", buf_out, m_out);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
  endtask

  initial begin
    m_out = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // fill, then overflow
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    step(1, 8'h44, 0);
    step(1, 8'h55, 0);
    // drain, then underflow
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    chk("hold_44", buf_out, 8'h44);
    // simultaneous at full
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0);
    step(1, 8'hB0, 1);
    chk("sim_full_out", buf_out, 8'hA0);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    chk("sim_full_last", buf_out, 8'hB0);
    // simultaneous at empty
    step(0, 0, 0, 1);
    step(1, 8'h5A, 1);
    step(0, 0, 1);
    chk("sim_empty_out", buf_out, 8'h5A);
    // wrap-around
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(i), 0);
      if (i % 3 == 2) while (q.size() > 0) step(0, 0, 1);
    end
    while (q.size() > 0) step(0, 0, 1);
    // flush with 3 entries and overflow set
    for (int i = 0; i < 5; i++) step(1, 8'hC0 + 8'(i), 0);
    step(0, 0, 1);
    step(1, 8'hEE, 0, 1);
    chk("flush_hold", buf_out, 8'hC0);
    // reset during a read
    step(1, 8'h77, 0);
    step(0, 0, 1, 0, 0);
    chk("rst_out", buf_out, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 60) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
